// File: rtl/rle_decompressor_pkg.sv
// Shared definitions for the RLE decompressor and the IO FSM that feeds it:
// state encoding, header tag values and default field widths.
package rle_decompressor_pkg;

    localparam int CNT_W_DEF = 7;
    localparam int OUT_W_DEF = 16;
    localparam int TAG_BIT   = 7;

    localparam logic TAG_ZERO = 1'b0;
    localparam logic TAG_LIT  = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_HDR    = 3'd1,
        ST_ZRUN   = 3'd2,
        ST_LIT_LO = 3'd3,
        ST_LIT_HI = 3'd4,
        ST_EMIT   = 3'd5,
        ST_DONE   = 3'd6
    } rle_state_e;

endpackage

// File: rtl/rle_decompressor_run_counter.sv
// Remaining-element counter for one run: loads header count + 1, counts down
// on each emitted element and saturates at one so it can never wrap.
module run_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         is_one
);

    logic [W-1:0] count_r;
    logic         is_one_s;

    assign is_one_s = (count_r == W'(1));
    assign is_one   = is_one_s;

    // Count register: load has priority, decrement stops at one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= {W{1'b0}};
        end else if (load) begin
            count_r <= load_val;
        end else if (dec && !is_one_s) begin
            count_r <= count_r - W'(1);
        end else begin
            count_r <= count_r;
        end
    end

endmodule

// File: rtl/rle_decompressor.sv
// Run-length decompressor: turns a header/literal byte stream into 16-bit
// elements (zero runs or little-endian literal pairs) with valid/ready flow.
module rle_decompressor
    import rle_decompressor_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int OUT_W = OUT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             eob,
    output logic [OUT_W-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             done,
    output logic             err
);

    rle_state_e       state_r, next_state_s;
    logic             in_ready_r, out_valid_r, busy_r, done_r, err_r, last_r;
    logic [OUT_W-1:0] out_data_r, out_data_next_s;
    logic [7:0]       lo_r, lo_next_s;
    logic             err_next_s, last_next_s;
    logic             cnt_load_s, cnt_dec_s, is_one_s;
    logic             in_fire_s, out_fire_s;
    logic [CNT_W:0]   load_val_s;

    assign in_fire_s  = in_valid & in_ready_r;
    assign out_fire_s = out_valid_r & out_ready;
    assign load_val_s = {1'b0, in_data[CNT_W-1:0]} + {{CNT_W{1'b0}}, 1'b1};

    run_counter #(
        .W (CNT_W + 1)
    ) u_run_counter (
        .clk      (clk),
        .rst_n    (reset),
        .load     (cnt_load_s),
        .load_val (load_val_s),
        .dec      (cnt_dec_s),
        .is_one   (is_one_s)
    );

    // Next-state and datapath decisions for the decode sequence.
    always_comb begin
        next_state_s    = state_r;
        err_next_s      = err_r;
        last_next_s     = last_r;
        lo_next_s       = lo_r;
        out_data_next_s = out_data_r;
        cnt_load_s      = 1'b0;
        cnt_dec_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    next_state_s = ST_HDR;
                    err_next_s   = 1'b0;
                    last_next_s  = 1'b0;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_HDR: begin
                if (in_fire_s) begin
                    cnt_load_s  = 1'b1;
                    last_next_s = eob;
                    if (in_data[TAG_BIT] == TAG_LIT) begin
                        next_state_s = ST_LIT_LO;
                    end else begin
                        next_state_s    = ST_ZRUN;
                        out_data_next_s = {OUT_W{1'b0}};
                    end
                end else begin
                    next_state_s = ST_HDR;
                end
            end
            ST_ZRUN: begin
                if (out_fire_s && is_one_s) begin
                    next_state_s = last_r ? ST_DONE : ST_HDR;
                end else if (out_fire_s) begin
                    cnt_dec_s = 1'b1;
                end else begin
                    next_state_s = ST_ZRUN;
                end
            end
            ST_LIT_LO: begin
                if (in_fire_s && eob) begin
                    err_next_s   = 1'b1;
                    next_state_s = ST_DONE;
                end else if (in_fire_s) begin
                    lo_next_s    = in_data;
                    next_state_s = ST_LIT_HI;
                end else begin
                    next_state_s = ST_LIT_LO;
                end
            end
            ST_LIT_HI: begin
                // eob on the final high byte of a run also ends the object
                if (in_fire_s && eob && !is_one_s) begin
                    err_next_s   = 1'b1;
                    next_state_s = ST_DONE;
                end else if (in_fire_s) begin
                    last_next_s     = last_r | eob;
                    out_data_next_s = OUT_W'({in_data, lo_r});
                    next_state_s    = ST_EMIT;
                end else begin
                    next_state_s = ST_LIT_HI;
                end
            end
            ST_EMIT: begin
                if (out_fire_s && is_one_s) begin
                    next_state_s = last_r ? ST_DONE : ST_HDR;
                end else if (out_fire_s) begin
                    cnt_dec_s    = 1'b1;
                    next_state_s = ST_LIT_LO;
                end else begin
                    next_state_s = ST_EMIT;
                end
            end
            ST_DONE: begin
                next_state_s = ST_IDLE;
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs, decoded from the state being entered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= ST_IDLE;
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
            out_data_r  <= {OUT_W{1'b0}};
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            err_r       <= 1'b0;
            last_r      <= 1'b0;
            lo_r        <= 8'h00;
        end else begin
            state_r     <= next_state_s;
            in_ready_r  <= (next_state_s == ST_HDR) || (next_state_s == ST_LIT_LO) ||
                           (next_state_s == ST_LIT_HI);
            out_valid_r <= (next_state_s == ST_ZRUN) || (next_state_s == ST_EMIT);
            out_data_r  <= out_data_next_s;
            busy_r      <= (next_state_s != ST_IDLE);
            done_r      <= (next_state_s == ST_DONE);
            err_r       <= err_next_s;
            last_r      <= last_next_s;
            lo_r        <= lo_next_s;
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign err       = err_r;

endmodule
